// File: rtl/fir_sched_pkg.sv
// Shared types and helpers for the FIR MAC scheduler: FSM state encoding,
// default MAC pipeline latency and packed-descriptor slice extraction.
package fir_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } sched_state_t;

  localparam int DEFAULT_MAC_LAT = 3;

  // Packed request vectors are zero-extended to this width before slicing.
  localparam int SLICE_VEC_W = 256;

  function automatic logic [31:0] req_slice(input logic [SLICE_VEC_W-1:0] vec,
                                            input int idx,
                                            input int width);
    logic [SLICE_VEC_W-1:0] shifted;
    logic [31:0] mask;
    shifted = vec >> (idx * width);
    mask = (32'h1 << width) - 32'h1;
    return shifted[31:0] & mask;
  endfunction

endpackage

// File: rtl/fir_mac_scheduler_rr_arbiter.sv
// Stateless round-robin priority search: the first requester at or above
// rr_ptr (wrapping upward) wins.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [IDX_W:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_REQ)) begin
        cand = cand - (IDX_W+1)'(N_REQ);
      end
      if (!any && req[cand[IDX_W-1:0]]) begin
        any                      = 1'b1;
        grant_idx                = cand[IDX_W-1:0];
        grant[cand[IDX_W-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Time-multiplexes one FIR multiply-accumulate engine between N_REQ
// requesters: round-robin job acceptance, clear/enable/address sequencing, done strobe.
module fir_mac_scheduler
  import fir_sched_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 9,
  parameter int CNT_W   = 10,
  parameter int MAC_LAT = DEFAULT_MAC_LAT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*ADDR_W-1:0]    req_base,
  input  logic [N_REQ*CNT_W-1:0]     req_taps,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       mac_clear,
  output logic                       mac_en,
  output logic [ADDR_W-1:0]          mac_tap_idx,
  output logic [ADDR_W-1:0]          mac_coeff_addr,
  output logic                       done_valid,
  output logic [$clog2(N_REQ)-1:0]   done_id,
  output logic                       busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int LAT_W = $clog2(MAC_LAT + 1);

  sched_state_t      state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  cur_id;
  logic [ADDR_W-1:0] cur_base;
  logic [CNT_W-1:0]  cur_taps;
  logic [CNT_W-1:0]  tap_cnt;
  logic [LAT_W-1:0]  drain_cnt;

  logic [N_REQ-1:0]  win_grant;
  logic [IDX_W-1:0]  win_idx;
  logic              win_any;
  logic [ADDR_W-1:0] sel_base;
  logic [CNT_W-1:0]  sel_taps;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (win_grant),
    .grant_idx (win_idx),
    .any       (win_any)
  );

  always_comb begin
    sel_base = ADDR_W'(req_slice(SLICE_VEC_W'(req_base), int'(win_idx), ADDR_W));
    sel_taps = CNT_W'(req_slice(SLICE_VEC_W'(req_taps), int'(win_idx), CNT_W));
  end

  // Outputs are registered from the state held in the previous cycle, so each
  // MAC control pulse appears one cycle after its state is entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      cur_id         <= '0;
      cur_base       <= '0;
      cur_taps       <= '0;
      tap_cnt        <= '0;
      drain_cnt      <= '0;
      req_ready      <= '0;
      mac_clear      <= 1'b0;
      mac_en         <= 1'b0;
      mac_tap_idx    <= '0;
      mac_coeff_addr <= '0;
      done_valid     <= 1'b0;
      done_id        <= '0;
      busy           <= 1'b0;
    end else begin
      req_ready      <= '0;
      mac_clear      <= 1'b0;
      mac_en         <= 1'b0;
      mac_tap_idx    <= '0;
      mac_coeff_addr <= '0;
      done_valid     <= 1'b0;
      done_id        <= '0;
      busy           <= (state != IDLE);
      unique case (state)
        IDLE: begin
          if (win_any) begin
            req_ready <= win_grant;
            cur_id    <= win_idx;
            cur_base  <= sel_base;
            cur_taps  <= sel_taps;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          mac_clear <= 1'b1;
          tap_cnt   <= '0;
          drain_cnt <= '0;
          state     <= (cur_taps != '0) ? RUN : DRAIN;
        end
        RUN: begin
          mac_en         <= 1'b1;
          mac_tap_idx    <= ADDR_W'(tap_cnt);
          mac_coeff_addr <= cur_base + ADDR_W'(tap_cnt);
          if (tap_cnt == cur_taps - CNT_W'(1)) begin
            state <= DRAIN;
          end else begin
            tap_cnt <= tap_cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == LAT_W'(MAC_LAT - 1)) begin
            state <= DONE;
          end else begin
            drain_cnt <= drain_cnt + LAT_W'(1);
          end
        end
        DONE: begin
          done_valid <= 1'b1;
          done_id    <= cur_id;
          rr_ptr     <= (cur_id == IDX_W'(N_REQ - 1)) ? '0 : cur_id + IDX_W'(1);
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Self-checking bench for fir_mac_scheduler: directed job sequences, a
// cycle-level timing/arbitration model and a scoreboard of expected grants.
module tb_fir_mac_scheduler;

  localparam int N  = 2;
  localparam int AW = 9;
  localparam int CW = 10;
  localparam int ML = 3;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_base;
  logic [N*CW-1:0] req_taps;
  logic [N-1:0]    req_ready;
  logic            mac_clear;
  logic            mac_en;
  logic [AW-1:0]   mac_tap_idx;
  logic [AW-1:0]   mac_coeff_addr;
  logic            done_valid;
  logic [$clog2(N)-1:0] done_id;
  logic            busy;

  fir_mac_scheduler #(
    .N_REQ   (N),
    .ADDR_W  (AW),
    .CNT_W   (CW),
    .MAC_LAT (ML)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_base       (req_base),
    .req_taps       (req_taps),
    .req_ready      (req_ready),
    .mac_clear      (mac_clear),
    .mac_en         (mac_en),
    .mac_tap_idx    (mac_tap_idx),
    .mac_coeff_addr (mac_coeff_addr),
    .done_valid     (done_valid),
    .done_id        (done_id),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Bench-side model of the job in flight
  logic act = 1'b0;
  int   acc, a_id, a_base, a_taps;
  int   m_rr = 0;
  int   base_arr[N];
  int   taps_arr[N];
  int   repost[N];
  int   exp_grants[$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int id, input int base, input int taps);
    base_arr[id] = base;
    taps_arr[id] = taps;
    req_base[id*AW +: AW] = AW'(base);
    req_taps[id*CW +: CW] = CW'(taps);
    req_valid[id] = 1'b1;
  endtask

  task automatic step();
    logic [N-1:0] pv;
    logic prst, any, e_clr, e_en, e_done;
    int wid, obs, e_idx, e_addr, done_cyc;
    pv  = req_valid;
    prst = rst;
    @(posedge clk);
    #1;
    cyc++;
    any = 1'b0;
    wid = 0;
    if (prst && !act && pv != '0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (!any && pv[j]) begin
          any = 1'b1;
          wid = j;
        end
      end
    end
    if (any) begin
      act = 1'b1; acc = cyc; a_id = wid;
      a_base = base_arr[wid]; a_taps = taps_arr[wid];
    end
    done_cyc = acc + a_taps + 2 + ML;
    e_clr  = act && (cyc == acc + 1);
    e_en   = act && (cyc >= acc + 2) && (cyc <= acc + a_taps + 1);
    e_idx  = e_en ? (cyc - acc - 2) : 0;
    e_addr = e_en ? ((a_base + e_idx) & ((1 << AW) - 1)) : 0;
    e_done = act && (cyc == done_cyc);
    checkOutput("req_ready", 32'(req_ready), any ? (32'h1 << wid) : 32'h0);
    checkOutput("mac_clear", 32'(mac_clear), 32'(e_clr));
    checkOutput("mac_en", 32'(mac_en), 32'(e_en));
    checkOutput("mac_tap_idx", 32'(mac_tap_idx), 32'(e_idx));
    checkOutput("mac_coeff_addr", 32'(mac_coeff_addr), 32'(e_addr));
    checkOutput("done_valid", 32'(done_valid), 32'(e_done));
    checkOutput("busy", 32'(busy), 32'(act && (cyc > acc)));
    if (e_done) checkOutput("done_id", 32'(done_id), 32'(a_id));
    if (req_ready != '0) begin
      obs = 0;
      for (int k = N - 1; k >= 0; k--) if (req_ready[k]) obs = k;
      if (exp_grants.size() == 0) checkOutput("grant_unexpected", 32'(obs), 32'hFFFF_FFFF);
      else checkOutput("grant_order", 32'(obs), 32'(exp_grants.pop_front()));
      for (int k = 0; k < N; k++) begin
        if (req_ready[k]) begin
          if (repost[k] > 0) repost[k]--;
          else req_valid[k] = 1'b0;
        end
      end
    end
    if (e_done) begin
      m_rr = (a_id + 1) % N;
      act = 1'b0;
    end
  endtask

  task automatic runJobs(input int bound);
    int n;
    n = 0;
    while ((act || exp_grants.size() != 0 || req_valid != '0) && n < bound) begin
      step();
      n++;
    end
    checkOutput("run_timeout", 32'(n < bound), 32'h1);
    step();
    step();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'h0);
    checkOutput({tag, "_clear"}, 32'(mac_clear), 32'h0);
    checkOutput({tag, "_en"}, 32'(mac_en), 32'h0);
    checkOutput({tag, "_idx"}, 32'(mac_tap_idx), 32'h0);
    checkOutput({tag, "_addr"}, 32'(mac_coeff_addr), 32'h0);
    checkOutput({tag, "_done"}, 32'(done_valid), 32'h0);
    checkOutput({tag, "_done_id"}, 32'(done_id), 32'h0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    int n;
    rst = 1'b0;
    req_valid = '0;
    req_base = '0;
    req_taps = '0;
    for (int i = 0; i < N; i++) begin
      base_arr[i] = 0; taps_arr[i] = 0; repost[i] = 0;
    end
    #3;
    checkAllZero("reset");
    step();
    step();
    rst = 1'b1;
    step();

    $display("[TB] simultaneous requests, taps=2");
    applyStimulus(0, 0, 2);
    applyStimulus(1, 100, 2);
    exp_grants.push_back(0);
    exp_grants.push_back(1);
    runJobs(100);
    applyStimulus(0, 40, 2);
    applyStimulus(1, 60, 2);
    exp_grants.push_back(0);
    exp_grants.push_back(1);
    runJobs(100);

    $display("[TB] single job base=16 taps=4");
    applyStimulus(0, 16, 4);
    exp_grants.push_back(0);
    runJobs(100);

    $display("[TB] alternating grants under continuous requests");
    repost[0] = 1;
    repost[1] = 1;
    applyStimulus(0, 3, 3);
    applyStimulus(1, 7, 1);
    exp_grants.push_back(1);
    exp_grants.push_back(0);
    exp_grants.push_back(1);
    exp_grants.push_back(0);
    runJobs(200);

    $display("[TB] address wrap base=510 taps=4");
    applyStimulus(1, 510, 4);
    exp_grants.push_back(1);
    runJobs(100);

    $display("[TB] zero-tap job");
    applyStimulus(0, 77, 0);
    exp_grants.push_back(0);
    runJobs(100);

    $display("[TB] reset during a long job");
    applyStimulus(0, 5, 1);
    exp_grants.push_back(0);
    runJobs(100);
    applyStimulus(1, 20, 100);
    exp_grants.push_back(1);
    n = 0;
    while (!(act && cyc >= acc + 10) && n < 200) begin
      step();
      n++;
    end
    checkOutput("reach_run_timeout", 32'(n < 200), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    checkAllZero("async_reset");
    act = 1'b0;
    m_rr = 0;
    step();
    applyStimulus(0, 8, 2);
    applyStimulus(1, 9, 2);
    step();
    rst = 1'b1;
    exp_grants.push_back(0);
    exp_grants.push_back(1);
    runJobs(100);

    checkOutput("grants_left", 32'(exp_grants.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
